// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: bram port bundle between the MAC sequencer and its memory
interface mac_sequencer_if #(
  parameter int AW       = 4,
  parameter int WORD_LEN = 8
);
  logic                mem_ena_o;
  logic                mem_wr_ena_o;
  logic [AW-1:0]       mem_rd_addr_1_o;
  logic [AW-1:0]       mem_rd_addr_2_o;
  logic [AW-1:0]       mem_wr_addr_o;
  logic [WORD_LEN-1:0] mem_data_o;
  logic [WORD_LEN-1:0] mem_data_1_i;
  logic [WORD_LEN-1:0] mem_data_2_i;
  modport master (
    output mem_ena_o, mem_wr_ena_o, mem_rd_addr_1_o, mem_rd_addr_2_o, mem_wr_addr_o, mem_data_o,
    input  mem_data_1_i, mem_data_2_i
  );
  modport slave (
    input  mem_ena_o, mem_wr_ena_o, mem_rd_addr_1_o, mem_rd_addr_2_o, mem_wr_addr_o, mem_data_o,
    output mem_data_1_i, mem_data_2_i
  );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: streams two bram vectors through a fixed-point MAC and writes back the saturated dot product
module mac_sequencer #(
  parameter int ADDR_LEN  = 16,
  parameter int WORD_LEN  = 8,
  parameter int FRAC_BITS = 4,
  localparam int AW       = $clog2(ADDR_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [AW-1:0]       a_base_i,
  input  logic [AW-1:0]       b_base_i,
  input  logic [AW-1:0]       res_addr_i,
  input  logic [AW:0]         len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WORD_LEN-1:0] result_o,
  mac_sequencer_if.master     mem
);
  localparam int ACCW = 2*WORD_LEN+AW+1;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  state_t                     state_q, state_d;
  logic [AW-1:0]              a_q, a_d, b_q, b_d, w_q, w_d;
  logic [AW:0]                cnt_q, cnt_d, len_c;
  logic signed [ACCW-1:0]     acc_q, acc_d, sh;
  logic signed [2*WORD_LEN-1:0] prod;
  logic                       vld_q, vld_d, ena_q, ena_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic [WORD_LEN-1:0]        data_q, data_d, res_q, res_d, sat;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] x);
    return x == AW'(ADDR_LEN-1) ? '0 : x + 1'b1;
  endfunction

  // next-state, accumulate and saturate; the write value is taken from acc_d so the last product lands in time
  always_comb begin
    len_c   = len_i > (AW+1)'(ADDR_LEN) ? (AW+1)'(ADDR_LEN) : len_i;
    prod    = $signed(mem.mem_data_1_i) * $signed(mem.mem_data_2_i);
    acc_d   = vld_q ? acc_q + ACCW'(prod) : acc_q;
    sh      = acc_d >>> FRAC_BITS;
    sat     = (&sh[ACCW-1:WORD_LEN-1] || ~|sh[ACCW-1:WORD_LEN-1]) ? sh[WORD_LEN-1:0]
              : {sh[ACCW-1], {(WORD_LEN-1){~sh[ACCW-1]}}};
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    vld_d   = state_q == READ;
    ena_d   = 1'b0;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    data_d  = data_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start_i) begin
        a_d     = a_base_i;
        b_d     = b_base_i;
        w_d     = res_addr_i;
        cnt_d   = len_c - 1'b1;
        acc_d   = '0;
        ena_d   = 1'b1;
        wr_d    = len_c == '0;
        data_d  = '0;
        state_d = len_c == '0 ? WRITE : READ;
      end
      READ: begin
        ena_d   = cnt_q != '0;
        state_d = cnt_q == '0 ? DRAIN : READ;
        a_d     = cnt_q == '0 ? a_q : inc(a_q);
        b_d     = cnt_q == '0 ? b_q : inc(b_q);
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      DRAIN: begin
        ena_d   = 1'b1;
        wr_d    = 1'b1;
        data_d  = sat;
        state_d = WRITE;
      end
      WRITE: begin
        res_d   = data_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  // state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      ena_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      ena_q   <= ena_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      res_q   <= res_d;
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign result_o            = res_q;
  assign mem.mem_ena_o       = ena_q;
  assign mem.mem_wr_ena_o    = wr_q;
  assign mem.mem_rd_addr_1_o = a_q;
  assign mem.mem_rd_addr_2_o = b_q;
  assign mem.mem_wr_addr_o   = w_q;
  assign mem.mem_data_o      = data_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: scoreboard bench with a bram model, directed dot-product jobs
module tb_mac_sequencer;
  typedef struct {int a1; int a2; int c;} rd_t;
  typedef struct {int a; int d; int c;} wr_t;
  typedef struct {int r; int c;} dn_t;

  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] a_base = 0, b_base = 0, res_addr = 0;
  logic [4:0] len = 0;
  logic       busy, done;
  logic [7:0] result;
  logic [7:0] bram [16];
  logic       ld = 0;
  logic [3:0] ld_a = 0;
  logic [7:0] ld_d = 0;
  logic       mon_en = 0, zero_chk = 0, fin = 0;
  int         cyc = 0, checks = 0, errors = 0;
  rd_t        rq[$];
  wr_t        wq[$];
  dn_t        dq[$];

  mac_sequencer_if #(.AW(4), .WORD_LEN(8)) mem_if();

  mac_sequencer #(.ADDR_LEN(16), .WORD_LEN(8), .FRAC_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_base_i(a_base), .b_base_i(b_base),
    .res_addr_i(res_addr), .len_i(len), .busy_o(busy), .done_o(done), .result_o(result),
    .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  // bram model: one-cycle read latency, zero when not reading
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) bram[ld_a] <= ld_d;
    else if (mem_if.mem_ena_o && mem_if.mem_wr_ena_o) bram[mem_if.mem_wr_addr_o] <= mem_if.mem_data_o;
    mem_if.mem_data_1_i <= (mem_if.mem_ena_o && !mem_if.mem_wr_ena_o) ? bram[mem_if.mem_rd_addr_1_o] : 8'd0;
    mem_if.mem_data_2_i <= (mem_if.mem_ena_o && !mem_if.mem_wr_ena_o) ? bram[mem_if.mem_rd_addr_2_o] : 8'd0;
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s: unexpected at cycle %0d", n, cyc);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a read, write or done
  always @(negedge clk) begin : mon
    rd_t r;
    wr_t w;
    dn_t d;
    if (mon_en) begin
      if (mem_if.mem_ena_o && !mem_if.mem_wr_ena_o) begin
        if (rq.size() == 0) bad("read");
        else begin
          r = rq.pop_front();
          chk("rd_addr_1", int'(mem_if.mem_rd_addr_1_o), r.a1);
          chk("rd_addr_2", int'(mem_if.mem_rd_addr_2_o), r.a2);
          chk("rd_cycle", cyc, r.c);
        end
      end
      if (mem_if.mem_wr_ena_o) begin
        if (wq.size() == 0) bad("write");
        else begin
          w = wq.pop_front();
          chk("wr_ena_pair", int'(mem_if.mem_ena_o), 1);
          chk("wr_addr", int'(mem_if.mem_wr_addr_o), w.a);
          chk("wr_data", int'($signed(mem_if.mem_data_o)), w.d);
          chk("wr_cycle", cyc, w.c);
        end
      end
      if (done) begin
        if (dq.size() == 0) bad("done");
        else begin
          d = dq.pop_front();
          chk("result", int'($signed(result)), d.r);
          chk("done_cycle", cyc, d.c);
          chk("busy_in_done", int'(busy), 1);
        end
      end
      if (zero_chk) begin
        chk("z_busy", int'(busy), 0);
        chk("z_done", int'(done), 0);
        chk("z_result", int'(result), 0);
        chk("z_ena", int'(mem_if.mem_ena_o), 0);
        chk("z_wr_ena", int'(mem_if.mem_wr_ena_o), 0);
        chk("z_rd_addr_1", int'(mem_if.mem_rd_addr_1_o), 0);
        chk("z_rd_addr_2", int'(mem_if.mem_rd_addr_2_o), 0);
        chk("z_wr_addr", int'(mem_if.mem_wr_addr_o), 0);
        chk("z_data", int'(mem_if.mem_data_o), 0);
      end
      if (fin) begin
        chk("rd_left", rq.size(), 0);
        chk("wr_left", wq.size(), 0);
        chk("done_left", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input int d);
    step();
    ld = 1;
    ld_a = 4'(a);
    ld_d = 8'(d);
    step();
    ld = 0;
  endtask

  task automatic issue(input int a, input int b, input int r, input int l, input int e, input bit full);
    int le, s;
    step();
    s = cyc;
    le = l > 16 ? 16 : l;
    a_base = 4'(a);
    b_base = 4'(b);
    res_addr = 4'(r);
    len = 5'(l);
    start = 1;
    for (int k = 0; k < (full ? le : 2); k++) rq.push_back('{(a + k) % 16, (b + k) % 16, s + 1 + k});
    if (full) begin
      wq.push_back('{r, e, le == 0 ? s + 1 : s + le + 2});
      dq.push_back('{e, le == 0 ? s + 2 : s + le + 3});
    end
    step();
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (rq.size() + wq.size() + dq.size()) != 0; i++) @(posedge clk);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    mon_en = 1;
    zero_chk = 1;
    step();
    zero_chk = 0;
    load(0, 16); load(1, 32); load(2, -16);
    load(4, 16); load(5, 16); load(6, 16);
    issue(0, 4, 10, 3, 32, 1);
    drain();
    for (int i = 0; i < 8; i++) load(i, 127);
    issue(0, 4, 11, 4, 127, 1);
    drain();
    for (int i = 8; i < 12; i++) load(i, -128);
    issue(0, 8, 12, 4, -128, 1);
    drain();
    load(14, 8); load(15, -8); load(0, 2); load(1, -3);
    issue(14, 14, 13, 4, 8, 1);
    drain();
    issue(0, 0, 3, 0, 0, 1);
    drain();
    issue(0, 4, 9, 5, -16, 1);
    step();
    a_base = 7; b_base = 2; res_addr = 1; len = 2; start = 1;
    step();
    start = 0;
    repeat (5) step();
    start = 1;
    step();
    start = 0;
    drain();
    issue(0, 4, 9, 5, -16, 0);
    step();
    rst = 1;
    step();
    rst = 0;
    zero_chk = 1;
    step();
    zero_chk = 0;
    issue(0, 4, 9, 5, -16, 1);
    drain();
    issue(0, 0, 15, 20, 127, 1);
    drain();
    fin = 1;
  end
endmodule
